vga_mode_sequencer: RTL

Run-time controller for the VGA timing generator. Holds a fixed table of four video modes and drives the generator's 32-bit timing inputs (H_Sync … V_TB_Border) and its two 16-bit colour inputs. Mode changes are requested through a req/ack handshake and applied only at a frame boundary, followed by a blanked settle period; colour updates are double-buffered and committed once per frame to prevent tearing.

---
 rtl/vga_mode_sequencer_if.sv | 23 ++
 rtl/vga_mode_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_sequencer_if.sv
// Mode-change handshake between a host controller and vga_mode_sequencer.
//   Mode_Sel    : requested mode index (host -> sequencer)
//   Mode_Req    : request strobe, sampled only while Busy is low
//   Mode_Ack    : one-cycle completion pulse (sequencer -> host)
//   Busy        : mode change in progress
//   Active_Mode : mode currently driven to the timing generator
interface vga_mode_sequencer_if;
  logic [1:0] Mode_Sel;
  logic       Mode_Req;
  logic       Mode_Ack;
  logic       Busy;
  logic [1:0] Active_Mode;

  modport master (
    output Mode_Sel, Mode_Req,
    input  Mode_Ack, Busy, Active_Mode
  );

  modport slave (
    input  Mode_Sel, Mode_Req,
    output Mode_Ack, Busy, Active_Mode
  );
endinterface

// File: rtl/vga_mode_sequencer.sv
// Run-time controller for the VGA timing generator.
// Holds a fixed four-entry video mode table and drives the generator's timing
// and colour inputs. Mode changes arrive over a req/ack handshake, are applied
// on a frame boundary (rising edge of VGA_VS_In) and followed by SETTLE_FRAMES
// frames of blanked output. Colours are double-buffered and committed once per
// frame.
// Ports:
//   pixel_clk, reset           : clock and synchronous active-high reset
//   mode_if (slave)            : Mode_Sel/Mode_Req in, Mode_Ack/Busy/Active_Mode out
//   VGA_VS_In                  : vertical sync from the timing generator
//   Color_Wr, In/Out_Color_Wdata : shadow colour write, {G[5:0],B[4:0],R[4:0]}
//   H_* / V_*                  : registered 32-bit timing values
//   InImage_Color, OutImage_Color : committed colours (0 while Blank)
//   Blank                      : high during the post-switch settle period
module vga_mode_sequencer #(
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned DEFAULT_MODE  = 0
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  vga_mode_sequencer_if.slave   mode_if,
  input  logic                  VGA_VS_In,
  input  logic                  Color_Wr,
  input  logic [15:0]           In_Color_Wdata,
  input  logic [15:0]           Out_Color_Wdata,
  output logic [31:0]           H_Sync,
  output logic [31:0]           H_BP,
  output logic [31:0]           H_FP,
  output logic [31:0]           H_Range,
  output logic [31:0]           H_LR_Border,
  output logic [31:0]           V_Sync,
  output logic [31:0]           V_BP,
  output logic [31:0]           V_FP,
  output logic [31:0]           V_Range,
  output logic [31:0]           V_TB_Border,
  output logic [15:0]           InImage_Color,
  output logic [15:0]           OutImage_Color,
  output logic                  Blank
);

  localparam logic [1:0]  DEF_MODE  = 2'(DEFAULT_MODE);
  localparam logic [15:0] IN_RESET  = 16'h001F;
  localparam logic [15:0] OUT_RESET = 16'h0000;

  typedef struct packed {
    logic [31:0] h_sync;
    logic [31:0] h_bp;
    logic [31:0] h_fp;
    logic [31:0] h_range;
    logic [31:0] h_border;
    logic [31:0] v_sync;
    logic [31:0] v_bp;
    logic [31:0] v_fp;
    logic [31:0] v_range;
    logic [31:0] v_border;
  } timing_t;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SETTLE} state_t;

  function automatic timing_t mode_timing(input logic [1:0] m);
    timing_t t;
    case (m)
      2'd0:    t = '{32'd96,  32'd48,  32'd16,  32'd640,  32'd0, 32'd2, 32'd33, 32'd10, 32'd480, 32'd0};
      2'd1:    t = '{32'd128, 32'd88,  32'd40,  32'd800,  32'd0, 32'd4, 32'd23, 32'd1,  32'd600, 32'd0};
      2'd2:    t = '{32'd136, 32'd160, 32'd24,  32'd1024, 32'd0, 32'd6, 32'd29, 32'd3,  32'd768, 32'd0};
      default: t = '{32'd40,  32'd220, 32'd110, 32'd1280, 32'd0, 32'd5, 32'd20, 32'd5,  32'd720, 32'd0};
    endcase
    return t;
  endfunction

  state_t      state;
  timing_t     timing_q;
  logic [1:0]  pend_mode;
  logic [1:0]  active_q;
  logic        busy_q;
  logic        ack_q;
  logic        blank_q;
  logic        blank_d;
  logic [31:0] settle_cnt;
  logic [31:0] settle_inc;
  logic        settle_last;
  logic        vs_q;
  logic        fe;

  logic [15:0] in_shadow, out_shadow;
  logic [15:0] in_commit, out_commit;
  logic [15:0] in_commit_d, out_commit_d;

  assign fe          = VGA_VS_In & ~vs_q;
  assign settle_inc  = settle_cnt + 32'd1;
  assign settle_last = (settle_inc == SETTLE_FRAMES);

  // Blank's next value is shared with the colour path so the colour outputs
  // go black on the same edge that loads the new timing.
  always_comb begin
    blank_d = blank_q;
    if (state == WAIT_FRAME && fe)
      blank_d = (SETTLE_FRAMES != 0);
    else if (state == SETTLE && fe && settle_last)
      blank_d = 1'b0;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) vs_q <= 1'b0;
    else       vs_q <= VGA_VS_In;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state      <= IDLE;
      timing_q   <= mode_timing(DEF_MODE);
      pend_mode  <= DEF_MODE;
      active_q   <= DEF_MODE;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      blank_q    <= 1'b0;
      settle_cnt <= '0;
    end else begin
      ack_q   <= 1'b0;
      blank_q <= blank_d;
      case (state)
        IDLE: begin
          if (mode_if.Mode_Req) begin
            if (mode_if.Mode_Sel == active_q) begin
              ack_q <= 1'b1;
            end else begin
              pend_mode <= mode_if.Mode_Sel;
              busy_q    <= 1'b1;
              state     <= WAIT_FRAME;
            end
          end
        end
        WAIT_FRAME: begin
          if (fe) begin
            timing_q   <= mode_timing(pend_mode);
            active_q   <= pend_mode;
            settle_cnt <= '0;
            if (SETTLE_FRAMES == 0) begin
              busy_q <= 1'b0;
              ack_q  <= 1'b1;
              state  <= IDLE;
            end else begin
              state  <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (fe) begin
            settle_cnt <= settle_inc;
            if (settle_last) begin
              busy_q <= 1'b0;
              ack_q  <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Commit sees the pre-write shadow when Color_Wr and fe coincide.
  assign in_commit_d  = fe ? in_shadow  : in_commit;
  assign out_commit_d = fe ? out_shadow : out_commit;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      in_shadow      <= IN_RESET;
      out_shadow     <= OUT_RESET;
      in_commit      <= IN_RESET;
      out_commit     <= OUT_RESET;
      InImage_Color  <= IN_RESET;
      OutImage_Color <= OUT_RESET;
    end else begin
      if (Color_Wr) begin
        in_shadow  <= In_Color_Wdata;
        out_shadow <= Out_Color_Wdata;
      end
      in_commit      <= in_commit_d;
      out_commit     <= out_commit_d;
      InImage_Color  <= blank_d ? '0 : in_commit_d;
      OutImage_Color <= blank_d ? '0 : out_commit_d;
    end
  end

  assign mode_if.Mode_Ack    = ack_q;
  assign mode_if.Busy        = busy_q;
  assign mode_if.Active_Mode = active_q;
  assign Blank               = blank_q;

  assign H_Sync      = timing_q.h_sync;
  assign H_BP        = timing_q.h_bp;
  assign H_FP        = timing_q.h_fp;
  assign H_Range     = timing_q.h_range;
  assign H_LR_Border = timing_q.h_border;
  assign V_Sync      = timing_q.v_sync;
  assign V_BP        = timing_q.v_bp;
  assign V_FP        = timing_q.v_fp;
  assign V_Range     = timing_q.v_range;
  assign V_TB_Border = timing_q.v_border;

endmodule
